// File: rtl/sync_fifo_pkg.sv
// Shared constants for the single-clock FIFO and its benches.
package sync_fifo_pkg;

  function automatic int unsigned depth_of(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_SIZE  = 4;
  localparam int unsigned DEPTH      = depth_of(ADDR_SIZE);
  localparam int unsigned CNT_W      = ADDR_SIZE + 1;
  localparam logic [DATA_WIDTH-1:0] DATA_RST = '0;

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage array for sync_fifo_top: synchronous write, asynchronous read.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int Data_Width = 8,
  parameter int Addr_Size  = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [Addr_Size-1:0]  waddr_i,
  input  logic [Data_Width-1:0] wdata_i,
  input  logic [Addr_Size-1:0]  raddr_i,
  output logic [Data_Width-1:0] rdata_o
);

  localparam int Depth = int'(depth_of(Addr_Size));

  logic [Data_Width-1:0] mem_q [Depth];

  // NOTE: storage has no reset; pointers and count define validity, so clearing the array buys nothing.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_top.sv
// Single-clock FIFO with fill count, programmable almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered output.
module sync_fifo_top
  import sync_fifo_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH,
  parameter int Addr_Size  = ADDR_SIZE
) (
  input  logic                  I_CLK,
  input  logic                  I_RST,
  input  logic                  I_W_INC,
  input  logic [Data_Width-1:0] I_Data,
  input  logic                  I_R_INC,
  input  logic [Addr_Size:0]    I_AF_Thr,
  input  logic [Addr_Size:0]    I_AE_Thr,
  input  logic                  I_Clr_Err,
  output logic [Data_Width-1:0] O_Data,
  output logic                  FIFO_Full,
  output logic                  FIFO_Empty,
  output logic                  O_Almost_Full,
  output logic                  O_Almost_Empty,
  output logic [Addr_Size:0]    O_Count,
  output logic                  O_Overflow,
  output logic                  O_Underflow
);

  localparam int Cnt_W = Addr_Size + 1;
  localparam logic [Cnt_W-1:0] DepthCnt = Cnt_W'(depth_of(Addr_Size));

  logic [Addr_Size-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Cnt_W-1:0]      count_q, count_d;
  logic [Data_Width-1:0] data_q, data_d, mem_rdata;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  full, empty, wr_acc, rd_acc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    full     = (count_q == DepthCnt);
    empty    = (count_q == '0);
    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    wr_acc   = I_W_INC & (~full | I_R_INC);
    rd_acc   = I_R_INC & ~empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + Addr_Size'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + Addr_Size'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + Cnt_W'(1);
      2'b01:   count_d = count_q - Cnt_W'(1);
      default: count_d = count_q;
    endcase
    data_d   = rd_acc ? mem_rdata : data_q;
    ovf_d    = (ovf_q & ~I_Clr_Err) | (I_W_INC & ~wr_acc);
    udf_d    = (udf_q & ~I_Clr_Err) | (I_R_INC & ~rd_acc);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge I_CLK or negedge I_RST) begin
    if (!I_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= Data_Width'(DATA_RST);
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sync_fifo_mem #(
    .Data_Width (Data_Width),
    .Addr_Size  (Addr_Size)
  ) u_mem (
    .clk_i   (I_CLK),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (I_Data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is visible while non-empty; data_q keeps the last consumed word for the empty case.
  assign O_Data = empty ? data_q : mem_rdata;
`else
  assign O_Data = data_q;
`endif

  assign FIFO_Full      = full;
  assign FIFO_Empty     = empty;
  assign O_Almost_Full  = (count_q >= I_AF_Thr);
  assign O_Almost_Empty = (count_q <= I_AE_Thr);
  assign O_Count        = count_q;
  assign O_Overflow     = ovf_q;
  assign O_Underflow    = udf_q;

endmodule
